// File: rtl/ram_param_if.sv
// ram_param_if: data-memory bus; i_in write data, i_address word address, i_load write enable, o_out registered read data, o_busy clear sweep active
interface ram_param_if #(
  parameter int WIDTH = 16,
  parameter int ADDR_BITS = 14
);
  logic [WIDTH-1:0] i_in;
  logic [ADDR_BITS-1:0] i_address;
  logic i_load;
  logic [WIDTH-1:0] o_out;
  logic o_busy;
  modport master (output i_in, i_address, i_load, input o_out, o_busy);
  modport slave (input i_in, i_address, i_load, output o_out, o_busy);
endinterface

// File: rtl/ram_param.sv
// ram_param: parametrised single-port RAM with registered read and post-reset clear sweep; ports clk, reset (sync active-high), bus (ram_param_if.slave: i_in, i_address, i_load, o_out, o_busy); RAM_BYPASS_EN selects write-first read-during-write
module ram_param #(
  parameter int WIDTH = 16,
  parameter int ADDR_BITS = 14,
  parameter int DEPTH = 16384
) (
  input logic clk,
  input logic reset,
  ram_param_if.slave bus
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t r_state;
  logic [ADDR_BITS-1:0] r_clr_addr;
  logic [WIDTH-1:0] r_out;
  logic r_busy;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic w_valid, w_wr, w_we;
  logic [IW-1:0] w_idx;
  logic [WIDTH-1:0] w_rd, w_next;
  assign w_valid = 33'(bus.i_address) < 33'(DEPTH);
  assign w_wr = bus.i_load && w_valid;
  assign w_rd = w_valid ? r_mem[IW'(bus.i_address)] : '0;
`ifdef RAM_BYPASS_EN
  assign w_next = w_wr ? bus.i_in : w_rd;
`else
  assign w_next = w_rd;
`endif
  // the sweep and normal writes share the single write port
  assign w_we = !reset && (r_state == CLEAR || w_wr);
  assign w_idx = r_state == CLEAR ? IW'(r_clr_addr) : IW'(bus.i_address);
  always_ff @(posedge clk)
    if (w_we) r_mem[w_idx] <= r_state == CLEAR ? '0 : bus.i_in;
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= CLEAR;
      r_clr_addr <= '0;
      r_out <= '0;
      r_busy <= 1'b1;
    end else if (r_state == CLEAR) begin
      r_clr_addr <= r_clr_addr + 1'b1;
      r_out <= '0;
      if (r_clr_addr == ADDR_BITS'(DEPTH - 1)) begin
        r_state <= IDLE;
        r_busy <= 1'b0;
      end
    end else r_out <= w_next;
  assign bus.o_out = r_out;
  assign bus.o_busy = r_busy;
endmodule

// File: tb/tb_ram_param.sv
// tb_ram_param: checks ram_param (default 16K build and a 1000-word/10-bit build) against a behavioural model every cycle plus literal expectations
module tb_ram_param;
  localparam int DB = 16384;
  localparam int DS = 1000;
`ifdef RAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  ram_param_if #(.WIDTH(16), .ADDR_BITS(14)) b_if ();
  ram_param_if #(.WIDTH(16), .ADDR_BITS(10)) s_if ();
  ram_param #(.WIDTH(16), .ADDR_BITS(14), .DEPTH(DB)) u_big (.clk(clk), .reset(reset), .bus(b_if.slave));
  ram_param #(.WIDTH(16), .ADDR_BITS(10), .DEPTH(DS)) u_small (.clk(clk), .reset(reset), .bus(s_if.slave));
  int checks = 0;
  int errors = 0;
  logic [15:0] mb [DB];
  logic [15:0] ms [DS];
  int bc = 0;
  int sc = 0;
  bit seen = 1'b0;
  logic [15:0] bout = '0;
  logic [15:0] sout = '0;
  // model: a reset starts a DEPTH-edge clear; afterwards the memory is all zero and accesses apply
  always @(posedge clk) begin
    if (reset) begin
      seen = 1'b1;
      bc = 0;
      sc = 0;
      bout = '0;
      sout = '0;
    end else begin
      if (bc < DB) begin
        bc++;
        bout = '0;
        if (bc == DB) foreach (mb[i]) mb[i] = '0;
      end else if (int'(b_if.i_address) < DB) begin
        bout = (b_if.i_load && BYP) ? b_if.i_in : mb[b_if.i_address];
        if (b_if.i_load) mb[b_if.i_address] = b_if.i_in;
      end else bout = '0;
      if (sc < DS) begin
        sc++;
        sout = '0;
        if (sc == DS) foreach (ms[i]) ms[i] = '0;
      end else if (int'(s_if.i_address) < DS) begin
        sout = (s_if.i_load && BYP) ? s_if.i_in : ms[s_if.i_address];
        if (s_if.i_load) ms[s_if.i_address] = s_if.i_in;
      end else sout = '0;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (seen) begin
      chk("big_busy", 32'(b_if.o_busy), 32'(bc < DB));
      chk("big_out", 32'(b_if.o_out), 32'(bout));
      chk("small_busy", 32'(s_if.o_busy), 32'(sc < DS));
      chk("small_out", 32'(s_if.o_out), 32'(sout));
    end
  endtask
  task automatic big(input logic [13:0] a, input logic [15:0] d, input logic l);
    b_if.i_address = a;
    b_if.i_in = d;
    b_if.i_load = l;
    step();
  endtask
  task automatic sml(input logic [9:0] a, input logic [15:0] d, input logic l);
    s_if.i_address = a;
    s_if.i_in = d;
    s_if.i_load = l;
    step();
  endtask
  int n;
  initial begin
    b_if.i_address = '0;
    b_if.i_in = '0;
    b_if.i_load = 1'b0;
    s_if.i_address = '0;
    s_if.i_in = '0;
    s_if.i_load = 1'b0;
    step();
    reset = 1'b1;
    step();
    step();
    chk("rst_busy_big", 32'(b_if.o_busy), 32'd1);
    chk("rst_out_big", 32'(b_if.o_out), 32'd0);
    chk("rst_busy_small", 32'(s_if.o_busy), 32'd1);
    chk("rst_out_small", 32'(s_if.o_out), 32'd0);
    reset = 1'b0;
    b_if.i_address = 14'd5;
    b_if.i_in = 16'hABCD;
    b_if.i_load = 1'b1;
    n = 0;
    while (s_if.o_busy && n < 5000) begin
      n++;
      step();
    end
    chk("small_sweep_len", 32'(n), 32'd1000);
    sml(10'd1010, 16'h1234, 1'b1);
    chk("oor_write_out", 32'(s_if.o_out), 32'd0);
    for (int a = 1010; a < 1024; a++) sml(10'(a), 16'h0, 1'b0);
    for (int a = 0; a < 24; a++) begin
      sml(10'(a), 16'h0, 1'b0);
      chk("oor_no_alias", 32'(s_if.o_out), 32'd0);
    end
    sml(10'd999, 16'h5A5A, 1'b1);
    sml(10'd999, 16'h0, 1'b0);
    chk("small_last_word", 32'(s_if.o_out), 32'h5A5A);
    n = 0;
    while (b_if.o_busy && n < 40000) begin
      n++;
      step();
    end
    chk("big_idle", 32'(b_if.o_busy), 32'd0);
    big(14'd5, 16'h0, 1'b0);
    chk("busy_write_dropped", 32'(b_if.o_out), 32'd0);
    big(14'd0, 16'h0, 1'b0);
    chk("clr_0", 32'(b_if.o_out), 32'd0);
    big(14'd1, 16'h0, 1'b0);
    chk("clr_1", 32'(b_if.o_out), 32'd0);
    big(14'd8192, 16'h0, 1'b0);
    chk("clr_mid", 32'(b_if.o_out), 32'd0);
    big(14'd16383, 16'h0, 1'b0);
    chk("clr_last", 32'(b_if.o_out), 32'd0);
    big(14'h0800, 16'h0001, 1'b1);
    big(14'h1000, 16'h0003, 1'b1);
    big(14'h0800, 16'h0, 1'b0);
    chk("rd_0800", 32'(b_if.o_out), 32'h0001);
    big(14'h1000, 16'h0, 1'b0);
    chk("rd_1000", 32'(b_if.o_out), 32'h0003);
    big(14'h1800, 16'h0007, 1'b0);
    big(14'h1800, 16'h0, 1'b0);
    chk("noload_1800", 32'(b_if.o_out), 32'd0);
    big(14'h17FF, 16'h0, 1'b0);
    chk("nbr_17ff", 32'(b_if.o_out), 32'd0);
    big(14'h1801, 16'h0, 1'b0);
    chk("nbr_1801", 32'(b_if.o_out), 32'd0);
    big(14'h0800, 16'h0, 1'b0);
    chk("keep_0800", 32'(b_if.o_out), 32'h0001);
    big(14'h0001, 16'h000F, 1'b1);
    big(14'h0001, 16'h00FF, 1'b1);
    chk("rdw_same_cycle", 32'(b_if.o_out), BYP ? 32'h00FF : 32'h000F);
    big(14'h0001, 16'h0, 1'b0);
    chk("rdw_next_read", 32'(b_if.o_out), 32'h00FF);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n = 0;
    while (b_if.o_busy && n < 40000) begin
      n++;
      step();
    end
    chk("restart_sweep_len", 32'(n), 32'(DB));
    big(14'h0800, 16'h0, 1'b0);
    chk("recleared_0800", 32'(b_if.o_out), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
